adder_rr_scheduler: RTL

Shares one instance of the team's 8-bit `prefix_adder` among 4 requesters.
- Each requester has its own valid/ready request channel.
- A round-robin arbiter picks one requester per cycle.
- The sum is captured in a one-entry output register with a valid/ready response channel.
- The block is the single access point to the shared adder in the datapath, and also keeps a count of completed operations.

---
 rtl/adder_rr_scheduler.sv | 134 +++++++++++++
 1 files changed

// File: rtl/adder_rr_scheduler.sv
// Round-robin scheduler sharing one 8-bit prefix adder among four requesters,
// with a one-entry registered response stage and a completed-operation counter.

module prefix_adder (
    input  logic [7:0] a,
    input  logic [7:0] b,
    output logic [7:0] sum
);

    logic [7:0] g0, p0, g1, p1, g2, p2, g3, p3;
    logic [7:0] carry;

    // Kogge-Stone carry tree, span 1/2/4; carry-in is zero, carry-out is dropped.
    always_comb begin
        g0 = a & b;
        p0 = a ^ b;
        g1 = g0;
        p1 = p0;
        g2 = '0;
        p2 = '0;
        g3 = '0;
        p3 = '0;
        for (int i = 1; i < 8; i++) begin
            g1[i] = g0[i] | (p0[i] & g0[i-1]);
            p1[i] = p0[i] & p0[i-1];
        end
        g2 = g1;
        p2 = p1;
        for (int i = 2; i < 8; i++) begin
            g2[i] = g1[i] | (p1[i] & g1[i-2]);
            p2[i] = p1[i] & p1[i-2];
        end
        g3 = g2;
        p3 = p2;
        for (int i = 4; i < 8; i++) begin
            g3[i] = g2[i] | (p2[i] & g2[i-4]);
            p3[i] = p2[i] & p2[i-4];
        end
        carry = {g3[6:0], 1'b0};
        sum   = p0 ^ carry;
    end

endmodule

module adder_rr_scheduler #(
    parameter int unsigned NREQ  = 4,
    parameter int unsigned WIDTH = 8,
    parameter int unsigned CNTW  = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NREQ-1:0]         req_valid,
    input  logic [NREQ*WIDTH-1:0]   req_a,
    input  logic [NREQ*WIDTH-1:0]   req_b,
    output logic [NREQ-1:0]         req_ready,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [WIDTH-1:0]        rsp_sum,
    output logic [1:0]              rsp_id,
    output logic [CNTW-1:0]         op_count
);

    typedef enum logic [0:0] {StEmpty, StFull} state_e;

    state_e          state;
    logic [1:0]      ptr;
    logic [1:0]      win;
    logic [1:0]      idx;
    logic            win_vld;
    logic            can_accept;
    logic            accept;
    logic            drain;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic [WIDTH-1:0] add_sum;

    // Scan from the highest offset down so the lowest offset from ptr wins.
    always_comb begin
        win     = ptr;
        win_vld = 1'b0;
        idx     = '0;
        for (int k = 3; k >= 0; k--) begin
            idx = ptr + 2'(k);
            if (req_valid[idx]) begin
                win     = idx;
                win_vld = 1'b1;
            end
        end
    end

    always_comb begin
        can_accept = (state == StEmpty) | (rsp_ready & rsp_valid);
        req_ready  = '0;
        if (rst_n && win_vld && can_accept) begin
            req_ready[win] = 1'b1;
        end
        accept = |req_ready;
        drain  = rsp_valid & rsp_ready;
        op_a   = win_vld ? req_a[{win, 3'b000} +: WIDTH] : '0;
        op_b   = win_vld ? req_b[{win, 3'b000} +: WIDTH] : '0;
    end

    prefix_adder u_adder (
        .a   (op_a),
        .b   (op_b),
        .sum (add_sum)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= StEmpty;
            ptr       <= '0;
            rsp_valid <= 1'b0;
            rsp_sum   <= '0;
            rsp_id    <= '0;
            op_count  <= '0;
        end else begin
            if (drain) begin
                op_count <= op_count + 1'b1;
            end
            if (accept) begin
                rsp_sum   <= add_sum;
                rsp_id    <= win;
                rsp_valid <= 1'b1;
                state     <= StFull;
                ptr       <= win + 2'd1;
            end else if (drain) begin
                rsp_valid <= 1'b0;
                state     <= StEmpty;
            end
        end
    end

endmodule
